// File: rtl/mul16_seq_if.sv
// ============================================================================
// Module   : mul16_seq_if
// Brief    : Operand/result handshake bundle for the mul16_seq multiplier.
//            master = operand producer / result consumer, slave = multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

`default_nettype wire

// File: rtl/mul16_seq.sv
// ============================================================================
// Module   : mul16_seq (plus its 16-bit ripple adder)
// Brief    : Sequential 16x16 unsigned shift-add multiplier, 32-bit product,
//            valid/ready on both sides. One adder pass per cycle.
// Options  : MUL_EARLY_EXIT_EN - finish as soon as the remaining multiplier
//            bits are all zero (latency min(16, msb(b)+2), 1 for b=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        c_out
);
  logic [16:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[16];
endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        rst,
  mul16_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] mcand;
  logic [15:0] hi;
  logic [15:0] lo;
  logic [3:0]  count;
  logic [31:0] product;

  logic [15:0] sum;
  logic        carry;
  logic [31:0] step_val;
  logic        last_iter;
  logic        early_fire;
  logic [31:0] early_val;
  logic        finish;

  // Running high half plus multiplicand; carry-out lands in hi[15] on shift.
  adder u_adder (
    .a     (hi),
    .b     (mcand),
    .c_in  (1'b0),
    .s     (sum),
    .c_out (carry)
  );

  // One shift-add step: add when the current multiplier bit (lo[0]) is set.
  always_comb begin
    step_val = {1'b0, hi, lo[15:1]};
    if (lo[0]) begin
      step_val = {carry, sum, lo[15:1]};
    end
  end

  assign last_iter = (count == 4'd15);

`ifdef MUL_EARLY_EXIT_EN
  // Copy of the unconsumed multiplier bits; zero means no more adds remain.
  logic [15:0] mreg;
  logic [4:0]  shamt;

  assign shamt      = 5'd16 - {1'b0, count};
  assign early_fire = (mreg == 16'd0);
  // Skipping the remaining pure shifts is one right shift of the accumulator.
  assign early_val  = {hi, lo} >> shamt;

  // Track remaining multiplier bits in step with lo.
  always_ff @(posedge clk) begin
    if (rst) begin
      mreg <= 16'd0;
    end else if (state == IDLE && bus.in_valid) begin
      mreg <= bus.b;
    end else if (state == RUN) begin
      mreg <= mreg >> 1;
    end
  end
`else
  assign early_fire = 1'b0;
  assign early_val  = 32'd0;
`endif

  assign finish = (state == RUN) && (last_iter || early_fire);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (finish) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= 16'd0;
      hi      <= 16'd0;
      lo      <= 16'd0;
      count   <= 4'd0;
      product <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand <= bus.a;
            lo    <= bus.b;
            hi    <= 16'd0;
            count <= 4'd0;
          end
        end
        RUN: begin
          if (early_fire) begin
            product <= early_val;
          end else begin
            {hi, lo} <= step_val;
            count    <= count + 4'd1;
            if (last_iter) begin
              product <= step_val;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.product = product;
endmodule

`default_nettype wire
